load_use_stall_unit: RTL

- Pipeline-interlock controller for the 5-stage MIPS core; sits beside the ID stage.
- Handles the hazards the forwarding units cannot cover: a load followed by a dependent instruction, and a BEQ/BNE compared in ID whose operand is still in flight.
- Tracks the destination of the instructions in EX and MEM in an internal two-slot scoreboard, driven only by what enters ID.
- Asserts `stall` to freeze PC/IF-ID and inject a bubble into ID/EX, and keeps a saturating stall counter for performance reporting.

---
 rtl/cpu_pkg.sv | 34 +++
 rtl/hazard_decode.sv | 64 ++++++
 rtl/load_use_stall_unit.sv | 96 +++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS core: opcodes, hazard scoreboard slot, stall causes.
package cpu_pkg;

    localparam int unsigned OP_W  = 6;
    localparam int unsigned REG_W = 5;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'd0;
    localparam logic [OP_W-1:0] OP_J     = 6'd2;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'd4;
    localparam logic [OP_W-1:0] OP_BNE   = 6'd5;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'd8;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'd10;
    localparam logic [OP_W-1:0] OP_LW    = 6'd35;
    localparam logic [OP_W-1:0] OP_SW    = 6'd43;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dest;
        logic             is_load;
    } sb_slot_t;

    typedef enum logic [1:0] {
        CAUSE_NONE        = 2'd0,
        CAUSE_LOAD_USE    = 2'd1,
        CAUSE_BR_EX       = 2'd2,
        CAUSE_BR_MEM_LOAD = 2'd3
    } stall_cause_e;

    // A slot matches a source register only if it holds a real write; $0 never matches.
    function automatic logic slot_hit(input sb_slot_t slot, input logic [REG_W-1:0] src);
        return slot.valid && (src != '0) && (slot.dest == src);
    endfunction

endpackage

// File: rtl/hazard_decode.sv
// Combinational opcode decode of destination/source usage; shared with the forwarding units.
module hazard_decode
    import cpu_pkg::*;
(
    input  logic [OP_W-1:0]  i_op,
    input  logic [REG_W-1:0] i_rs,
    input  logic [REG_W-1:0] i_rt,
    input  logic [REG_W-1:0] i_rd,
    output logic [REG_W-1:0] o_dest_c,
    output logic             o_has_dest_c,
    output logic             o_uses_rs_c,
    output logic             o_uses_rt_c,
    output logic             o_is_load_c,
    output logic             o_is_branch_c
);

    logic w_writes;
    logic w_reads_rs;
    logic w_reads_rt;

    always_comb begin
        o_dest_c      = '0;
        w_writes      = 1'b0;
        w_reads_rs    = 1'b0;
        w_reads_rt    = 1'b0;
        o_is_load_c   = 1'b0;
        o_is_branch_c = 1'b0;
        case (i_op)
            OP_RTYPE: begin
                o_dest_c   = i_rd;
                w_writes   = 1'b1;
                w_reads_rs = 1'b1;
                w_reads_rt = 1'b1;
            end
            OP_LW: begin
                o_dest_c    = i_rt;
                w_writes    = 1'b1;
                w_reads_rs  = 1'b1;
                o_is_load_c = 1'b1;
            end
            OP_ADDI, OP_SLTI: begin
                o_dest_c   = i_rt;
                w_writes   = 1'b1;
                w_reads_rs = 1'b1;
            end
            OP_SW: begin
                w_reads_rs = 1'b1;
                w_reads_rt = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                w_reads_rs    = 1'b1;
                w_reads_rt    = 1'b1;
                o_is_branch_c = 1'b1;
            end
            default: ;
        endcase
    end

    // Register $0 is hardwired, so it is neither a real destination nor a real source.
    assign o_has_dest_c = w_writes && (o_dest_c != '0);
    assign o_uses_rs_c  = w_reads_rs && (i_rs != '0);
    assign o_uses_rt_c  = w_reads_rt && (i_rt != '0);

endmodule

// File: rtl/load_use_stall_unit.sv
// ID-stage interlock: tracks EX/MEM destinations and stalls on load-use and early-branch hazards.
module load_use_stall_unit
    import cpu_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             IDvalid,
    input  logic [OP_W-1:0]  IDop,
    input  logic [REG_W-1:0] IDrs,
    input  logic [REG_W-1:0] IDrt,
    input  logic [REG_W-1:0] IDrd,
    output logic             stall,
    output logic [1:0]       stall_cause,
    output logic [CNT_W-1:0] stall_count
);

    logic [REG_W-1:0] w_dest;
    logic             w_has_dest;
    logic             w_uses_rs;
    logic             w_uses_rt;
    logic             w_is_load;
    logic             w_is_branch;

    sb_slot_t         r_ex;
    sb_slot_t         r_mem;
    sb_slot_t         w_ex_next;
    logic             w_ex_hit;
    logic             w_mem_hit;
    stall_cause_e     w_cause;
    logic [CNT_W-1:0] r_count;

    hazard_decode u_decode (
        .i_op          (IDop),
        .i_rs          (IDrs),
        .i_rt          (IDrt),
        .i_rd          (IDrd),
        .o_dest_c      (w_dest),
        .o_has_dest_c  (w_has_dest),
        .o_uses_rs_c   (w_uses_rs),
        .o_uses_rt_c   (w_uses_rt),
        .o_is_load_c   (w_is_load),
        .o_is_branch_c (w_is_branch)
    );

    assign w_ex_hit  = (w_uses_rs && slot_hit(r_ex, IDrs))  || (w_uses_rt && slot_hit(r_ex, IDrt));
    assign w_mem_hit = (w_uses_rs && slot_hit(r_mem, IDrs)) || (w_uses_rt && slot_hit(r_mem, IDrt));

    // Priority: branch-on-EX, then branch-on-MEM-load, then plain load-use.
    always_comb begin
        w_cause = CAUSE_NONE;
        if (IDvalid) begin
            if (w_is_branch && w_ex_hit) begin
                w_cause = CAUSE_BR_EX;
            end else if (w_is_branch && w_mem_hit && r_mem.is_load) begin
                w_cause = CAUSE_BR_MEM_LOAD;
            end else if (!w_is_branch && w_ex_hit && r_ex.is_load) begin
                w_cause = CAUSE_LOAD_USE;
            end
        end
    end

    assign stall       = (w_cause != CAUSE_NONE);
    assign stall_cause = 2'(w_cause);
    assign stall_count = r_count;

    always_comb begin
        w_ex_next = '0;
        if (IDvalid && !stall) begin
            w_ex_next.valid   = w_has_dest;
            w_ex_next.dest    = w_dest;
            w_ex_next.is_load = w_is_load;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex  <= '0;
            r_mem <= '0;
        end else begin
            r_mem <= r_ex;
            r_ex  <= w_ex_next;
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (stall && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule
